// File: rtl/types.sv
// Shared ALU operation codes used by the control FSM and the datapath ALU.
package types;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } oper_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle between the multicycle control FSM (master) and the
// datapath plus memory (slave).
interface multicycle_control_if #(
  parameter int CNT_W = 32
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              zero;
  logic              mem_ready;
  types::oper_t      alu_sel;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        pc_source;
  logic              pc_en;
  logic              i_or_d;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              reg_dst;
  logic              mem_to_reg;
  logic              reg_write;
  logic              illegal;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_sel, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_sel, alu_src_a, alu_src_b, pc_source, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal, retired
  );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences each instruction FETCH..WRITEBACK, drives the
// ALU and datapath muxes, handshakes with memory and counts retired instructions.
module multicycle_control
  import types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB
  } state_t;

  typedef struct packed {
    oper_t       alu_sel;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_source;
    logic        pc_en;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        illegal;
  } ctrl_t;

  state_t            state_q, state_d;
  ctrl_t             ctrl;
  logic              retire;
  logic [CNT_W-1:0]  retired_q;
  oper_t             r_oper;
  logic              funct_ok;

  // R-type funct decode; checked in DECODE, applied in EXECUTE.
  always_comb begin
    r_oper   = OP_ADD;
    funct_ok = 1'b1;
    case (bus.funct)
      6'b100100: r_oper = OP_AND;
      6'b100101: r_oper = OP_OR;
      6'b100000: r_oper = OP_ADD;
      6'b100010: r_oper = OP_SUB;
      6'b101010: r_oper = OP_SLT;
      6'b100111: r_oper = OP_NOR;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets its default before the case, so no path infers a latch.
    state_d       = state_q;
    ctrl          = '0;
    ctrl.alu_sel  = OP_ADD;
    retire        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.ir_write  = bus.mem_ready;
          ctrl.pc_en     = bus.mem_ready;
          if (bus.mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          ctrl.alu_src_b = 2'b11;
          case (bus.opcode)
            OPC_R:          state_d = funct_ok ? S_EXECUTE : S_FETCH;
            OPC_LW, OPC_SW: state_d = S_MEM_ADDR;
            OPC_BEQ:        state_d = S_BRANCH;
            OPC_J:          state_d = S_JUMP;
            OPC_ADDI:       state_d = S_ADDI_EX;
            default:        state_d = S_FETCH;
          endcase
          ctrl.illegal = (state_d == S_FETCH);
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
          state_d = (bus.opcode == OPC_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
          if (bus.mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
          if (bus.mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_EXECUTE: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_sel   = r_oper;
          state_d = S_R_WB;
        end
        S_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          // Branch target was latched into ALUOut during DECODE.
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_sel   = OP_SUB;
          ctrl.pc_source = 2'b01;
          ctrl.pc_en     = bus.zero;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          ctrl.pc_source = 2'b10;
          ctrl.pc_en     = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
          state_d = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          ctrl.reg_write = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.alu_sel    = ctrl.alu_sel;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.pc_en      = ctrl.pc_en;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.illegal    = ctrl.illegal;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected outputs go through a
// scoreboard queue and are checked with immediate assertions.
module tb_multicycle_control;
  import types::*;

  typedef struct packed {
    oper_t       alu_sel;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_source;
    logic        pc_en;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        illegal;
  } outs_t;

  typedef struct {
    string        tag;
    bit           sel;
    outs_t        o;
    logic [31:0]  ret;
  } exp_t;

  typedef enum {P_RST, P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_RWB,
                P_BR, P_J, P_AE, P_AWB} phase_e;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         clk = 1'b0;
  logic         rst_a, rst_b;
  logic [31:0]  ret_a;
  logic [3:0]   ret_b;

  logic [5:0] fn_tab [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b100111};
  oper_t      op_tab [6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) ifa ();
  multicycle_control_if #(.CNT_W(4))  ifb ();

  multicycle_control #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.master));
  multicycle_control #(.CNT_W(4))  dut_b (.clk(clk), .rst(rst_b), .bus(ifb.master));

  function automatic outs_t model(phase_e p, logic mr, logic z, oper_t ex_op, logic bad);
    outs_t o;
    o = '0;
    o.alu_sel = OP_ADD;
    case (p)
      P_F:   begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      P_D:   begin o.alu_src_b = 2'b11; o.illegal = bad; end
      P_MA:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MR:  begin o.mem_read = 1; o.i_or_d = 1; end
      P_MWB: begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MW:  begin o.mem_write = 1; o.i_or_d = 1; end
      P_EX:  begin o.alu_src_a = 1; o.alu_sel = ex_op; end
      P_RWB: begin o.reg_write = 1; o.reg_dst = 1; end
      P_BR:  begin o.alu_src_a = 1; o.alu_sel = OP_SUB; o.pc_source = 2'b01; o.pc_en = z; end
      P_J:   begin o.pc_source = 2'b10; o.pc_en = 1; end
      P_AE:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_AWB: o.reg_write = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t observe(bit sel);
    outs_t o;
    if (sel)
      o = '{ifb.alu_sel, ifb.alu_src_a, ifb.alu_src_b, ifb.pc_source, ifb.pc_en, ifb.i_or_d,
            ifb.mem_read, ifb.mem_write, ifb.ir_write, ifb.reg_dst, ifb.mem_to_reg,
            ifb.reg_write, ifb.illegal};
    else
      o = '{ifa.alu_sel, ifa.alu_src_a, ifa.alu_src_b, ifa.pc_source, ifa.pc_en, ifa.i_or_d,
            ifa.mem_read, ifa.mem_write, ifa.ir_write, ifa.reg_dst, ifa.mem_to_reg,
            ifa.reg_write, ifa.illegal};
    return o;
  endfunction

  // One clock cycle: queue the expectation, check at negedge, then step the edge.
  task automatic cyc(input string tag, input bit sel, input phase_e p, input bit retire,
                     input oper_t ex_op = OP_ADD, input bit bad = 1'b0);
    exp_t         e;
    outs_t        obs;
    logic [31:0]  obs_ret;
    e.tag = tag;
    e.sel = sel;
    e.o   = sel ? model(p, ifb.mem_ready, ifb.zero, ex_op, bad)
                : model(p, ifa.mem_ready, ifa.zero, ex_op, bad);
    e.ret = sel ? 32'(ret_b) : ret_a;
    sb.push_back(e);
    @(negedge clk);
    e       = sb.pop_front();
    obs     = observe(e.sel);
    obs_ret = e.sel ? 32'(ifb.retired) : ifa.retired;
    n_cmp++;
    assert (obs === e.o) else begin
      n_bad++;
      $error("FAIL %s ctrl: observed %h expected %h", e.tag, obs, e.o);
    end
    n_cmp++;
    assert (obs_ret === e.ret) else begin
      n_bad++;
      $error("FAIL %s retired: observed %0d expected %0d", e.tag, obs_ret, e.ret);
    end
    @(posedge clk);
    #1;
    if (sel) begin
      if (rst_b) ret_b = '0;
      else if (retire) ret_b = ret_b + 4'd1;
    end else begin
      if (rst_a) ret_a = '0;
      else if (retire) ret_a = ret_a + 32'd1;
    end
  endtask

  initial begin
    rst_a = 1; rst_b = 1;
    ifa.opcode = '0; ifa.funct = '0; ifa.zero = 0; ifa.mem_ready = 1;
    ifb.opcode = JMP; ifb.funct = '0; ifb.zero = 0; ifb.mem_ready = 1;
    ret_a = '0; ret_b = '0;
    @(posedge clk);
    #1;
    cyc("reset0", 0, P_RST, 0);
    cyc("reset1", 0, P_RST, 0);
    rst_a = 0;

    // Every legal R-type funct, zero-wait memory.
    for (int i = 0; i < 6; i++) begin
      ifa.opcode = '0;
      ifa.funct  = fn_tab[i];
      cyc($sformatf("r%0d_f", i),  0, P_F,   0);
      cyc($sformatf("r%0d_d", i),  0, P_D,   0);
      cyc($sformatf("r%0d_ex", i), 0, P_EX,  0, op_tab[i]);
      cyc($sformatf("r%0d_wb", i), 0, P_RWB, 1);
    end

    // lw with memory stalling three cycles in MEM_READ.
    ifa.opcode = LW;
    cyc("lw_f", 0, P_F, 0);
    cyc("lw_d", 0, P_D, 0);
    cyc("lw_ma", 0, P_MA, 0);
    ifa.mem_ready = 0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw_mr_wait%0d", i), 0, P_MR, 0);
    ifa.mem_ready = 1;
    cyc("lw_mr", 0, P_MR, 0);
    cyc("lw_wb", 0, P_MWB, 1);

    // sw with one fetch wait state.
    ifa.opcode = SW;
    ifa.mem_ready = 0;
    cyc("sw_f_wait", 0, P_F, 0);
    ifa.mem_ready = 1;
    cyc("sw_f", 0, P_F, 0);
    cyc("sw_d", 0, P_D, 0);
    cyc("sw_ma", 0, P_MA, 0);
    cyc("sw_mw", 0, P_MW, 1);

    // addi
    ifa.opcode = ADDI;
    cyc("addi_f", 0, P_F, 0);
    cyc("addi_d", 0, P_D, 0);
    cyc("addi_ex", 0, P_AE, 0);
    cyc("addi_wb", 0, P_AWB, 1);

    // beq taken then not taken; both retire.
    ifa.opcode = BEQ;
    for (int t = 1; t >= 0; t--) begin
      ifa.zero = 1'(t);
      cyc($sformatf("beq%0d_f", t),  0, P_F,  0);
      cyc($sformatf("beq%0d_d", t),  0, P_D,  0);
      cyc($sformatf("beq%0d_br", t), 0, P_BR, 1);
    end
    ifa.zero = 0;

    // Illegal opcode, then illegal funct, then a legal instruction afterwards.
    ifa.opcode = 6'b111111;
    cyc("ill_op_f", 0, P_F, 0);
    cyc("ill_op_d", 0, P_D, 0, OP_ADD, 1'b1);
    ifa.opcode = '0;
    ifa.funct  = 6'b000001;
    cyc("ill_fn_f", 0, P_F, 0);
    cyc("ill_fn_d", 0, P_D, 0, OP_ADD, 1'b1);
    ifa.funct  = 6'b100101;
    cyc("post_ill_f", 0, P_F, 0);
    cyc("post_ill_d", 0, P_D, 0);
    cyc("post_ill_ex", 0, P_EX, 0, OP_OR);
    cyc("post_ill_wb", 0, P_RWB, 1);

    // Reset while a store is waiting on memory.
    ifa.opcode = SW;
    cyc("rsw_f", 0, P_F, 0);
    cyc("rsw_d", 0, P_D, 0);
    cyc("rsw_ma", 0, P_MA, 0);
    ifa.mem_ready = 0;
    cyc("rsw_mw_wait", 0, P_MW, 0);
    rst_a = 1;
    cyc("rsw_rst", 0, P_RST, 0);
    rst_a = 0;
    ifa.mem_ready = 1;
    cyc("rsw_after_f", 0, P_F, 0);
    cyc("rsw_after_d", 0, P_D, 0);

    // 4-bit counter instance: 16 jumps wrap retired 15 -> 0.
    cyc("b_reset", 1, P_RST, 0);
    rst_b = 0;
    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("j%0d_f", i), 1, P_F, 0);
      cyc($sformatf("j%0d_d", i), 1, P_D, 0);
      cyc($sformatf("j%0d_j", i), 1, P_J, 1);
    end
    cyc("j_wrap_f", 1, P_F, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
